// File: rtl/rect_obuf_mc.sv
// rect_obuf_mc: packs per-channel pixel byte streams into 32-bit words with
// byte enables, queues one command per line segment, and replays each
// segment to the DDR arbiter as a power-of-two write burst
// (command beat, address beat, data beats, zero pad beats).
module rect_obuf_mc #(
  parameter int unsigned NCH    = 2,
  parameter int unsigned STRIDE = 640,
  parameter int unsigned Y_W    = 9,
  parameter int unsigned X_W    = 10,
  parameter int unsigned DFF_AW = 10,
  parameter int unsigned CFF_AW = 6,
  parameter int unsigned ADDR_W = 20,
  localparam int unsigned CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              enb,
  input  logic [12*NCH-1:0] base_a,
  input  logic [12*NCH-1:0] base_b,
  output logic              in_rdy,
  input  logic              vin,
  input  logic              last,
  input  logic [CH_W-1:0]   ch,
  input  logic [Y_W-1:0]    ydst,
  input  logic [X_W-1:0]    xdst,
  input  logic [6:0]        len,
  input  logic [7:0]        intp,
  output logic [NCH-1:0]    frm_end,
  output logic              drop_err,
  output logic [7:0]        drop_cnt,
  output logic              ddr_req,
  input  logic              ddr_ack,
  output logic [31:0]       ddr_dout,
  output logic [3:0]        ddr_strb,
  output logic              ddr_vout
);

  localparam int unsigned DDEPTH = 1 << DFF_AW;
  localparam int unsigned CDEPTH = 1 << CFF_AW;

  typedef struct packed {
    logic            last;
    logic [CH_W-1:0] ch;
    logic [Y_W-1:0]  y;
    logic [X_W-3:0]  xw;
    logic [5:0]      wm1;
  } cmd_t;

  typedef struct packed {
    logic [3:0]  strb;
    logic [31:0] data;
  } word_t;

  typedef enum logic [2:0] {
    S_IDLE, S_POP, S_WAIT, S_ADDR, S_DATA, S_PAD, S_DONE
  } state_t;

  // reset and disable share one flush path
  logic flush_c;
  assign flush_c = srst | ~enb;

  // ---------------- write side ----------------
  logic [6:0]  bidx_q;
  logic        sdrop_q;
  logic [31:0] wdat_q;
  logic [3:0]  wstb_q;
  logic        in_rdy_q;
  logic        drop_err_q;
  logic [7:0]  drop_cnt_q;

  logic        seg_start_c, drop_c, last_byte_c, byte_we_c, dpush_c, cpush_c;
  logic [1:0]  phase_c;
  logic [31:0] mdat_c;
  logic [3:0]  mstb_c;
  cmd_t        cmd_in_c;

  // byte lane placement, word/command push decisions
  always_comb begin
    seg_start_c = vin & (bidx_q == 7'd0);
    drop_c      = seg_start_c ? ~in_rdy_q : sdrop_q;
    last_byte_c = vin & ((bidx_q + 7'd1) == len);
    phase_c     = xdst[1:0] + bidx_q[1:0];
    byte_we_c   = vin & ~drop_c;
    mdat_c      = wdat_q | (32'(intp) << {phase_c, 3'b000});
    mstb_c      = wstb_q | (4'b0001 << phase_c);
    dpush_c     = byte_we_c & ((phase_c == 2'd3) | last_byte_c);
    cpush_c     = byte_we_c & last_byte_c;
    cmd_in_c    = '{last: last, ch: ch, y: ydst, xw: xdst[X_W-1:2],
                    wm1: 6'((8'(xdst[1:0]) + 8'(len) - 8'd1) >> 2)};
  end

  // segment tracking, word accumulator and drop bookkeeping
  always_ff @(posedge clk) begin
    if (flush_c) begin
      bidx_q     <= '0;
      sdrop_q    <= 1'b0;
      wdat_q     <= '0;
      wstb_q     <= '0;
      drop_err_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (vin) begin
      bidx_q <= last_byte_c ? 7'd0 : 7'(bidx_q + 7'd1);
      if (seg_start_c) begin
        sdrop_q <= ~in_rdy_q;
        if (!in_rdy_q) begin
          drop_err_q <= 1'b1;
          if (drop_cnt_q != 8'hFF) drop_cnt_q <= 8'(drop_cnt_q + 8'd1);
        end
      end
      if (byte_we_c) begin
        wdat_q <= dpush_c ? 32'd0 : mdat_c;
        wstb_q <= dpush_c ? 4'd0 : mstb_c;
      end
    end
  end

  // ---------------- FIFOs ----------------
  word_t dmem [DDEPTH];
  cmd_t  cmem [CDEPTH];

  logic [DFF_AW-1:0] dwp_q, drp_q;
  logic [DFF_AW:0]   dcnt_q, dcnt_d;
  logic [CFF_AW-1:0] cwp_q, crp_q;
  logic [CFF_AW:0]   ccnt_q, ccnt_d;
  logic              dpop_c, cpop_c;
  word_t             dhead_c;
  cmd_t              chead_c;

  assign dhead_c = dmem[drp_q];
  assign chead_c = cmem[crp_q];

  // occupancy after this cycle's push/pop
  always_comb begin
    dcnt_d = dcnt_q + (DFF_AW+1)'(dpush_c) - (DFF_AW+1)'(dpop_c);
    ccnt_d = ccnt_q + (CFF_AW+1)'(cpush_c) - (CFF_AW+1)'(cpop_c);
  end

  // storage; pointers alone define valid contents
  always_ff @(posedge clk) begin
    if (dpush_c && !flush_c) dmem[dwp_q] <= '{strb: mstb_c, data: mdat_c};
    if (cpush_c && !flush_c) cmem[cwp_q] <= cmd_in_c;
  end

  // pointers, counts and the registered ready flag
  always_ff @(posedge clk) begin
    if (flush_c) begin
      dwp_q    <= '0;
      drp_q    <= '0;
      dcnt_q   <= '0;
      cwp_q    <= '0;
      crp_q    <= '0;
      ccnt_q   <= '0;
      in_rdy_q <= 1'b0;
    end else begin
      if (dpush_c) dwp_q <= DFF_AW'(dwp_q + 1'b1);
      if (dpop_c)  drp_q <= DFF_AW'(drp_q + 1'b1);
      if (cpush_c) cwp_q <= CFF_AW'(cwp_q + 1'b1);
      if (cpop_c)  crp_q <= CFF_AW'(crp_q + 1'b1);
      dcnt_q   <= dcnt_d;
      ccnt_q   <= ccnt_d;
      in_rdy_q <= (dcnt_d <= (DFF_AW+1)'(DDEPTH - 33)) &
                  (ccnt_d <= (CFF_AW+1)'(CDEPTH - 2));
    end
  end

  // ---------------- read side ----------------
  state_t            state_q;
  logic              last_q;
  logic [CH_W-1:0]   ch_q;
  logic [5:0]        wm1_q;
  logic [7:0]        bl_m1_q;
  logic [31:0]       addr_q;
  logic [5:0]        bcnt_q;
  logic              req_q;
  logic [31:0]       dout_q;
  logic [3:0]        strb_q;
  logic [NCH-1:0]    frm_end_q;
  logic [NCH-1:0]    frame_q;
  logic [11:0]       bsel_c;
  logic [ADDR_W-1:0] off_c;

  // burst length minus one: next power of two >= words, clamped to 4..64
  function automatic logic [7:0] bl_m1_f(input logic [5:0] wm1);
    if (wm1 < 6'd4)       return 8'd3;
    else if (wm1 < 6'd8)  return 8'd7;
    else if (wm1 < 6'd16) return 8'd15;
    else if (wm1 < 6'd32) return 8'd31;
    else                  return 8'd63;
  endfunction

  // frame base of the head command's channel and its in-frame offset
  always_comb begin
    bsel_c = '0;
    for (int k = 0; k < NCH; k++) begin
      if (chead_c.ch == CH_W'(k))
        bsel_c = frame_q[k] ? base_b[12*k +: 12] : base_a[12*k +: 12];
    end
    off_c = ADDR_W'(ADDR_W'(chead_c.y) * ADDR_W'(STRIDE)) +
            ADDR_W'({chead_c.xw, 2'b00});
  end

  assign cpop_c = (state_q == S_POP);
  assign dpop_c = (state_q == S_ADDR) |
                  ((state_q == S_DATA) & (bcnt_q != wm1_q));

  // burst sequencer; bus registers always hold the beat of the current cycle
  always_ff @(posedge clk) begin
    if (flush_c) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b0;
      ch_q      <= '0;
      wm1_q     <= '0;
      bl_m1_q   <= '0;
      addr_q    <= '0;
      bcnt_q    <= '0;
      req_q     <= 1'b0;
      dout_q    <= '0;
      strb_q    <= 4'hF;
      frm_end_q <= '0;
      frame_q   <= '0;
    end else begin
      frm_end_q <= '0;
      case (state_q)
        S_IDLE: if (ccnt_q != '0) state_q <= S_POP;
        S_POP: begin
          last_q  <= chead_c.last;
          ch_q    <= chead_c.ch;
          wm1_q   <= chead_c.wm1;
          bl_m1_q <= bl_m1_f(chead_c.wm1);
          addr_q  <= 32'({bsel_c, off_c});
          dout_q  <= {22'b0, chead_c.last, 1'b0, bl_m1_f(chead_c.wm1)};
          strb_q  <= 4'h0;
          req_q   <= 1'b1;
          state_q <= S_WAIT;
        end
        S_WAIT: if (ddr_ack) begin
          dout_q  <= addr_q;
          state_q <= S_ADDR;
        end
        S_ADDR: begin
          dout_q  <= dhead_c.data;
          strb_q  <= dhead_c.strb;
          bcnt_q  <= '0;
          state_q <= S_DATA;
        end
        S_DATA: begin
          if (bcnt_q == wm1_q) begin
            if (8'(wm1_q) == bl_m1_q) begin
              req_q   <= 1'b0;
              dout_q  <= '0;
              strb_q  <= 4'hF;
              state_q <= S_DONE;
            end else begin
              dout_q  <= '0;
              strb_q  <= 4'h0;
              bcnt_q  <= 6'(bcnt_q + 6'd1);
              state_q <= S_PAD;
            end
          end else begin
            dout_q <= dhead_c.data;
            strb_q <= dhead_c.strb;
            bcnt_q <= 6'(bcnt_q + 6'd1);
          end
        end
        S_PAD: begin
          if (8'(bcnt_q) == bl_m1_q) begin
            req_q   <= 1'b0;
            dout_q  <= '0;
            strb_q  <= 4'hF;
            state_q <= S_DONE;
          end else begin
            bcnt_q <= 6'(bcnt_q + 6'd1);
          end
        end
        S_DONE: begin
          for (int k = 0; k < NCH; k++) begin
            if (last_q && (ch_q == CH_W'(k))) begin
              frm_end_q[k] <= 1'b1;
              frame_q[k]   <= ~frame_q[k];
            end
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_rdy   = in_rdy_q;
  assign drop_err = drop_err_q;
  assign drop_cnt = drop_cnt_q;
  assign ddr_req  = req_q;
  assign ddr_dout = dout_q;
  assign ddr_strb = strb_q;
  assign frm_end  = frm_end_q;
  assign ddr_vout = req_q & ddr_ack;

endmodule

// File: tb/tb_rect_obuf_mc.sv
// Bench for rect_obuf_mc: random segments against a byte-level reference
// model; expected beats are queued at issue time and popped by a monitor.
module tb_rect_obuf_mc;
  localparam int unsigned NCH    = 2;
  localparam int unsigned STRIDE = 640;
  localparam int unsigned ADDR_W = 20;

  logic        clk = 1'b0;
  logic        srst, enb, vin, last, ddr_ack;
  logic [23:0] base_a, base_b;
  logic [0:0]  ch;
  logic [8:0]  ydst;
  logic [9:0]  xdst;
  logic [6:0]  len;
  logic [7:0]  intp;
  logic        in_rdy, drop_err, ddr_req, ddr_vout;
  logic [1:0]  frm_end;
  logic [7:0]  drop_cnt;
  logic [31:0] ddr_dout;
  logic [3:0]  ddr_strb;

  always #5 clk = ~clk;

  rect_obuf_mc #(.NCH(NCH), .STRIDE(STRIDE), .Y_W(9), .X_W(10), .DFF_AW(10),
                 .CFF_AW(6), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .srst(srst), .enb(enb), .base_a(base_a), .base_b(base_b),
    .in_rdy(in_rdy), .vin(vin), .last(last), .ch(ch), .ydst(ydst),
    .xdst(xdst), .len(len), .intp(intp), .frm_end(frm_end),
    .drop_err(drop_err), .drop_cnt(drop_cnt), .ddr_req(ddr_req),
    .ddr_ack(ddr_ack), .ddr_dout(ddr_dout), .ddr_strb(ddr_strb),
    .ddr_vout(ddr_vout));

  int total = 0;
  int bad   = 0;
  logic [35:0] expq[$];
  int          feq[$];
  int          frame_m[NCH];
  int          drops_m = 0;
  bit          stall = 1'b0;
  logic [11:0] base_am[NCH];
  logic [11:0] base_bm[NCH];

  function automatic void check(input string nm, input logic [63:0] act,
                                input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // arbiter: grants after a random delay, holds the grant while req is high
  initial begin
    ddr_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!ddr_req) ddr_ack = 1'b0;
      else if (!ddr_ack && !stall && ($urandom_range(0, 2) == 0)) ddr_ack = 1'b1;
    end
  end

  // monitor: every transferred beat and every frame-end pulse is checked
  always @(negedge clk) begin
    logic [35:0] e;
    if (ddr_vout) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL beat_unexpected actual=%0h required=none", {ddr_dout, ddr_strb});
      end else begin
        e = expq.pop_front();
        check("beat", 64'({ddr_dout, ddr_strb}), 64'(e));
      end
    end
    for (int k = 0; k < NCH; k++) begin
      if (frm_end[k]) begin
        if (feq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL frm_end_unexpected actual=ch%0d required=none", k);
        end else begin
          check("frm_end_ch", 64'(k), 64'(feq.pop_front()));
        end
      end
    end
  end

  // issue one segment; model its burst unless the ready flag says it is dropped
  task automatic send_seg(input int c, input int y, input int x, input int l,
                          input bit lst, input bit any_rdy);
    int r, prev, guard, n, bl, pos;
    bit ok;
    logic [7:0]  b[128];
    logic [31:0] wd[33];
    logic [3:0]  ws[33];
    logic [11:0] bs;
    logic [19:0] off;
    prev = -1; guard = 0; ok = 1'b0; r = 0;
    while (!ok) begin
      r = int'(in_rdy);
      if (r == prev && (any_rdy || r == 1)) ok = 1'b1;
      else begin
        prev = r;
        tick();
        guard++;
        if (guard > 20000) begin
          total++;
          bad++;
          $display("FAIL rdy_wait actual=timeout required=in_rdy");
          return;
        end
      end
    end
    for (int i = 0; i < l; i++) b[i] = 8'($urandom);
    if (r == 0) begin
      if (drops_m < 255) drops_m++;
    end else begin
      n = (x % 4 + l + 3) / 4;
      bl = 4;
      while (bl < n) bl = bl * 2;
      bs  = (frame_m[c] != 0) ? base_bm[c] : base_am[c];
      off = 20'((y * STRIDE + (x / 4) * 4) % (1 << ADDR_W));
      expq.push_back({32'((lst ? 512 : 0) + bl - 1), 4'h0});
      expq.push_back({bs, off, 4'h0});
      for (int j = 0; j < 33; j++) begin
        wd[j] = '0;
        ws[j] = '0;
      end
      for (int i = 0; i < l; i++) begin
        pos = x % 4 + i;
        wd[pos / 4][8 * (pos % 4) +: 8] = b[i];
        ws[pos / 4][pos % 4] = 1'b1;
      end
      for (int j = 0; j < bl; j++) begin
        if (j < n) expq.push_back({wd[j], ws[j]});
        else       expq.push_back(36'h0);
      end
      if (lst) begin
        feq.push_back(c);
        frame_m[c] = 1 - frame_m[c];
      end
    end
    ch = 1'(c); ydst = 9'(y); xdst = 10'(x); len = 7'(l); last = lst;
    for (int i = 0; i < l; i++) begin
      intp = b[i];
      vin  = 1'b1;
      tick();
      if (i < l - 1 && $urandom_range(0, 4) == 0) begin
        vin = 1'b0;
        tick();
      end
    end
    vin = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (expq.size() != 0 && guard < 10000) begin
      tick();
      guard++;
    end
    if (expq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain actual=%0d_beats_left required=0", expq.size());
    end
    repeat (6) tick();
  endtask

  initial begin
    #900000;
    total++;
    bad++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int sz, guard;
    base_am[0] = 12'hA00; base_am[1] = 12'hA01;
    base_bm[0] = 12'hB00; base_bm[1] = 12'hB01;
    base_a = {base_am[1], base_am[0]};
    base_b = {base_bm[1], base_bm[0]};
    for (int k = 0; k < NCH; k++) frame_m[k] = 0;
    srst = 1'b1; enb = 1'b1; vin = 1'b0; last = 1'b0; ch = '0;
    ydst = '0; xdst = '0; len = 7'd1; intp = '0;
    repeat (3) tick();
    check("rst_in_rdy", 64'(in_rdy), 64'(0));
    check("rst_req", 64'(ddr_req), 64'(0));
    check("rst_dout", 64'(ddr_dout), 64'(0));
    check("rst_strb", 64'(ddr_strb), 64'(4'hF));
    check("rst_frm_end", 64'(frm_end), 64'(0));
    check("rst_drop_err", 64'(drop_err), 64'(0));
    check("rst_drop_cnt", 64'(drop_cnt), 64'(0));
    srst = 1'b0;
    repeat (3) tick();

    // single byte at the top lane, then a full-length last segment and a
    // follow-up on the same channel which must use frame B
    send_seg(1, 0, 3, 1, 1'b0, 1'b0);
    drain();
    send_seg(0, 2, 1, 127, 1'b1, 1'b0);
    drain();
    send_seg(0, 5, 8, 20, 1'b0, 1'b0);
    send_seg(1, 4, 0, 16, 1'b0, 1'b0);
    drain();
    // interleaved channels, only channel 0 ends its frame
    send_seg(0, 10, 40, 30, 1'b0, 1'b0);
    send_seg(1, 11, 41, 45, 1'b0, 1'b0);
    send_seg(0, 12, 42, 7, 1'b1, 1'b0);
    drain();
    // random traffic
    for (int i = 0; i < 30; i++)
      send_seg($urandom_range(0, 1), $urandom_range(0, 479), $urandom_range(0, 639),
               $urandom_range(1, 127), ($urandom_range(0, 3) == 0), 1'b0);
    drain();

    // backpressure: hold the grant off until a segment gets dropped
    stall = 1'b1;
    guard = 0;
    while (drops_m == 0 && guard < 300) begin
      send_seg($urandom_range(0, 1), $urandom_range(0, 479), $urandom_range(0, 639),
               $urandom_range(1, 6), 1'b0, 1'b1);
      guard++;
    end
    tick();
    check("bp_in_rdy", 64'(in_rdy), 64'(0));
    check("bp_drop_err", 64'(drop_err), 64'(1));
    check("bp_drop_cnt", 64'(drop_cnt), 64'(drops_m));
    stall = 1'b0;
    drain();

    // reset in the middle of a burst's data phase
    send_seg(1, 7, 12, 100, 1'b0, 1'b0);
    sz = expq.size();
    guard = 0;
    while (expq.size() > sz - 5 && guard < 5000) begin
      tick();
      guard++;
    end
    check("rst_mid_reached_data", 64'(expq.size() <= sz - 5), 64'(1));
    srst = 1'b1;
    tick();
    srst = 1'b0;
    expq.delete();
    feq.delete();
    for (int k = 0; k < NCH; k++) frame_m[k] = 0;
    drops_m = 0;
    check("rst_mid_req", 64'(ddr_req), 64'(0));
    check("rst_mid_drop_cnt", 64'(drop_cnt), 64'(0));
    repeat (5) tick();
    check("rst_mid_idle", 64'(ddr_req), 64'(0));
    send_seg(1, 3, 5, 9, 1'b1, 1'b0);
    drain();

    check("end_beats_left", 64'(expq.size()), 64'(0));
    check("end_frm_end_left", 64'(feq.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
